uart_rx: RTL and testbench

- Serial receiver for the UART path; the receive-side counterpart to the transmit path and its baud generator.
- Decodes asynchronous 8-bit frames on `rx`: 1 start bit, 8 data bits LSB-first, optional parity, 1 stop bit.
- Has its own 16x-oversampling tick divider, selected by the same 2-bit `baud_rate` code the transmit side uses.
- Presents each received byte through a one-entry holding register with a valid/ack handshake.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_if.sv | 32 +++
 rtl/uart_os_tick.sv | 58 +++++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - Baud codes (2-bit, shared with the transmit side).
//   - Oversampling factor and divisor helper: DIV = round(CLK_HZ / (baud * 16)).
//   - Receiver FSM state encoding.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DEF_CLK_HZ = 6250000;

  // Rounded divisor for one oversample tick.
  function automatic int unsigned div_calc(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

  // Reference divisors at the default 6.25 MHz clock: 163 / 81 / 41 / 20.
  localparam int unsigned DIV_2400  = div_calc(DEF_CLK_HZ, 2400);
  localparam int unsigned DIV_4800  = div_calc(DEF_CLK_HZ, 4800);
  localparam int unsigned DIV_9600  = div_calc(DEF_CLK_HZ, 9600);
  localparam int unsigned DIV_19200 = div_calc(DEF_CLK_HZ, 19200);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: signal bundle between the UART receiver and its environment.
//   rx         serial input, idle high
//   baud_rate  2-bit baud code
//   data_out   received byte, stable while data_valid
//   data_valid holding register full
//   data_ack   consumer takes the byte
//   parity_err parity mismatch for data_out
//   frame_err  one-cycle pulse on a low stop bit
//   overrun    sticky: byte overwritten while data_valid
//   busy       receiver not idle
// master: the receiver side; slave: the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [1:0] baud_rate;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx, baud_rate, data_ack,
    output data_out, data_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output rx, baud_rate, data_ack,
    input  data_out, data_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_os_tick.sv
// uart_os_tick: 16x oversampling tick generator.
//   clock      system clock
//   rst        synchronous active-high reset
//   en         run the divider; held at 0 while low
//   baud_rate  baud code, captured while en is low and frozen while en is high
//   tick       one-cycle pulse every DIV clocks while enabled
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 6250000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] baud_rate,
  output logic       tick
);

  localparam logic [15:0] DM1_2400  = 16'(div_calc(CLK_HZ, 2400)  - 1);
  localparam logic [15:0] DM1_4800  = 16'(div_calc(CLK_HZ, 4800)  - 1);
  localparam logic [15:0] DM1_9600  = 16'(div_calc(CLK_HZ, 9600)  - 1);
  localparam logic [15:0] DM1_19200 = 16'(div_calc(CLK_HZ, 19200) - 1);

  logic [1:0]  baud_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_m1;

  always_comb begin
    unique case (baud_q)
      BAUD_2400:  div_m1 = DM1_2400;
      BAUD_4800:  div_m1 = DM1_4800;
      BAUD_9600:  div_m1 = DM1_9600;
      default:    div_m1 = DM1_19200;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!en)                  cnt_d = '0;
    else if (cnt_q == div_m1) cnt_d = '0;
    else                      cnt_d = cnt_q + 16'd1;
  end

  assign tick = en && (cnt_q == div_m1);

  // The code tracks the input while idle, so the value present on the
  // enabling edge is the one held for the whole frame.
  always_ff @(posedge clock) begin
    if (rst) begin
      baud_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (!en) baud_q <= baud_rate;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, 16x oversampled.
// Frame: start, D0..D7 (LSB first), optional parity, one stop bit.
//   clock  system clock (rising edge)
//   rst    synchronous active-high reset
//   bus    uart_rx_if.master: rx/baud_rate/data_ack in;
//          data_out/data_valid/parity_err/frame_err/overrun/busy out
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 6250000,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input logic      clock,
  input logic      rst,
  uart_rx_if.master bus
);

  rx_state_e  state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       perr_pend_q, perr_pend_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       fe_q, fe_d;
  logic       ovr_q, ovr_d;
  logic       load;
  logic       tick;

  uart_os_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clock     (clock),
    .rst       (rst),
    .en        (state_q != IDLE),
    .baud_rate (bus.baud_rate),
    .tick      (tick)
  );

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    fe_d        = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        scnt_d = '0;
        bcnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (tick) begin
          if (scnt_q == 4'd7) begin
            scnt_d  = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            perr_pend_d = rx_s_q ^ (^shift_q) ^ PARITY_ODD;
            state_d     = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            if (rx_s_q) begin
              load    = 1'b1;
              state_d = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register. A completing byte always loads; an ack in the same
  // cycle consumes the old byte, so overrun is raised only without an ack.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = shift_q;
      perr_d  = PARITY_EN ? perr_pend_q : 1'b0;
      valid_d = 1'b1;
      if (valid_q && !bus.data_ack) ovr_d = 1'b1;
      else if (bus.data_ack)        ovr_d = 1'b0;
    end else if (bus.data_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      fe_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= bus.rx;
      rx_s_q      <= rx_meta_q;
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      fe_q        <= fe_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a byte scoreboard.
// Two receivers: u_dut0 without parity, u_dut1 with even parity.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       pe;
  } exp_t;

  logic clk;
  logic rst;
  logic rx0, rx1;
  logic [1:0] baud0, baud1;
  logic ack0, ack1;

  int n_cmp  = 0;
  int n_fail = 0;
  int fe0 = 0, fe1 = 0;
  int busy_cnt0 = 0;
  int vrise0 = 0;
  logic vprev0 = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  uart_rx_if u_if0();
  uart_rx_if u_if1();

  assign u_if0.rx        = rx0;
  assign u_if0.baud_rate = baud0;
  assign u_if0.data_ack  = ack0;
  assign u_if1.rx        = rx1;
  assign u_if1.baud_rate = baud1;
  assign u_if1.data_ack  = ack1;

  uart_rx #(.CLK_HZ(6250000), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .clock (clk),
    .rst   (rst),
    .bus   (u_if0)
  );

  uart_rx #(.CLK_HZ(6250000), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clock (clk),
    .rst   (rst),
    .bus   (u_if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (u_if0.frame_err) fe0++;
    if (u_if1.frame_err) fe1++;
    if (u_if0.busy) busy_cnt0++;
    if (u_if0.data_valid && !vprev0) vrise0++;
    vprev0 = u_if0.data_valid;
  end

  function automatic logic exp_perr(input logic [7:0] d, input bit odd, input bit pbit);
    return ((^d) ^ odd) != pbit;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic hold_bit(input int which, input logic v, input int bitp);
    set_rx(which, v);
    repeat (bitp) @(negedge clk);
  endtask

  // chg: switch the baud code to 2400 right after the start bit and
  // restore it after the frame (the receiver must ignore it).
  task automatic send(input int which, input logic [7:0] d, input bit pen,
                      input bit pbit, input bit stop, input int bitp, input bit chg);
    logic [1:0] saved;
    saved = (which == 0) ? baud0 : baud1;
    @(negedge clk);
    hold_bit(which, 1'b0, bitp);
    if (chg) begin
      if (which == 0) baud0 = BAUD_2400;
      else            baud1 = BAUD_2400;
    end
    for (int i = 0; i < 8; i++) hold_bit(which, d[i], bitp);
    if (pen) hold_bit(which, pbit, bitp);
    hold_bit(which, stop, bitp);
    if (chg) begin
      if (which == 0) baud0 = saved;
      else            baud1 = saved;
    end
  endtask

  task automatic wait_valid(input int which, input string tag);
    int n;
    n = 0;
    while (((which == 0) ? u_if0.data_valid : u_if1.data_valid) !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'((which == 0) ? u_if0.data_valid : u_if1.data_valid), 32'd1);
  endtask

  task automatic check_head(input int which, input string tag);
    exp_t e;
    int   sz;
    sz = (which == 0) ? q0.size() : q1.size();
    chk({tag, "_qsize"}, 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      e = (which == 0) ? q0[0] : q1[0];
      chk({tag, "_data"}, 32'((which == 0) ? u_if0.data_out : u_if1.data_out), 32'(e.d));
      chk({tag, "_perr"}, 32'((which == 0) ? u_if0.parity_err : u_if1.parity_err), 32'(e.pe));
    end
  endtask

  task automatic do_ack(input int which);
    @(negedge clk);
    if (which == 0) ack0 = 1'b1; else ack1 = 1'b1;
    @(negedge clk);
    if (which == 0) ack0 = 1'b0; else ack1 = 1'b0;
    if (which == 0) begin
      if (q0.size() != 0) void'(q0.pop_front());
    end else begin
      if (q1.size() != 0) void'(q1.pop_front());
    end
  endtask

  initial begin
    int fe_b, vr_b, bc_b;
    rst = 1'b1;
    rx0 = 1'b1; rx1 = 1'b1;
    baud0 = BAUD_9600; baud1 = BAUD_19200;
    ack0 = 1'b0; ack1 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_data",  32'(u_if0.data_out),   32'h0);
    chk("rst_valid", 32'(u_if0.data_valid), 32'd0);
    chk("rst_perr",  32'(u_if0.parity_err), 32'd0);
    chk("rst_fe",    32'(u_if0.frame_err),  32'd0);
    chk("rst_ovr",   32'(u_if0.overrun),    32'd0);
    chk("rst_busy",  32'(u_if0.busy),       32'd0);
    chk("rst_valid1",32'(u_if1.data_valid), 32'd0);

    // 9600, no parity, 0xA5
    fe_b = fe0;
    q0.push_back('{d: 8'hA5, pe: 1'b0});
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 656, 1'b0);
    wait_valid(0, "a5_valid");
    check_head(0, "a5");
    chk("a5_fe", 32'(fe0 - fe_b), 32'd0);
    repeat (3) @(negedge clk);
    do_ack(0);
    chk("a5_ack_valid", 32'(u_if0.data_valid), 32'd0);

    // 19200, even parity, correct parity bit then wrong parity bit
    q1.push_back('{d: 8'h03, pe: exp_perr(8'h03, 1'b0, 1'b0)});
    send(1, 8'h03, 1'b1, 1'b0, 1'b1, 320, 1'b0);
    wait_valid(1, "p0_valid");
    check_head(1, "p0");
    do_ack(1);
    q1.push_back('{d: 8'h03, pe: exp_perr(8'h03, 1'b0, 1'b1)});
    send(1, 8'h03, 1'b1, 1'b1, 1'b1, 320, 1'b1);
    wait_valid(1, "p1_valid");
    check_head(1, "p1");
    chk("p1_fe", 32'(fe1), 32'd0);
    do_ack(1);

    // 2400, 5-clock glitch
    baud0 = BAUD_2400;
    fe_b = fe0; vr_b = vrise0; bc_b = busy_cnt0;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (5) @(negedge clk);
    rx0 = 1'b1;
    repeat (3000) @(negedge clk);
    chk("gl_busy_seen", 32'(busy_cnt0 != bc_b), 32'd1);
    chk("gl_busy_end",  32'(u_if0.busy), 32'd0);
    chk("gl_valid",     32'(vrise0 - vr_b), 32'd0);
    chk("gl_fe",        32'(fe0 - fe_b), 32'd0);

    // 4800, 0x55 with low stop bit, then line held low
    baud0 = BAUD_4800;
    fe_b = fe0; vr_b = vrise0;
    send(0, 8'h55, 1'b0, 1'b0, 1'b0, 1296, 1'b0);
    repeat (3 * 1296) @(negedge clk);
    chk("br_fe_once",  32'(fe0 - fe_b), 32'd1);
    chk("br_valid",    32'(u_if0.data_valid), 32'd0);
    chk("br_busy",     32'(u_if0.busy), 32'd1);
    rx0 = 1'b1;
    repeat (6) @(negedge clk);
    chk("br_idle",     32'(u_if0.busy), 32'd0);
    chk("br_fe_final", 32'(fe0 - fe_b), 32'd1);
    chk("br_vrise",    32'(vrise0 - vr_b), 32'd0);

    // 19200, overrun: 0x11 then 0x22 without ack
    baud0 = BAUD_19200;
    q0.push_back('{d: 8'h11, pe: 1'b0});
    send(0, 8'h11, 1'b0, 1'b0, 1'b1, 320, 1'b0);
    wait_valid(0, "o1_valid");
    check_head(0, "o1");
    chk("o1_ovr", 32'(u_if0.overrun), 32'd0);
    q0.push_back('{d: 8'h22, pe: 1'b0});
    send(0, 8'h22, 1'b0, 1'b0, 1'b1, 320, 1'b0);
    void'(q0.pop_front());
    check_head(0, "o2");
    chk("o2_ovr",   32'(u_if0.overrun), 32'd1);
    chk("o2_valid", 32'(u_if0.data_valid), 32'd1);
    do_ack(0);
    chk("o2_ack_valid", 32'(u_if0.data_valid), 32'd0);
    chk("o2_ack_ovr",   32'(u_if0.overrun), 32'd0);

    // Reset mid-DATA of 0xFF, then clean 0x3C
    fe_b = fe0; vr_b = vrise0;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (320) @(negedge clk);
    rx0 = 1'b1;
    repeat (3 * 320) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6 * 320) @(negedge clk);
    chk("rs_busy",  32'(u_if0.busy), 32'd0);
    chk("rs_vrise", 32'(vrise0 - vr_b), 32'd0);
    q0.push_back('{d: 8'h3C, pe: 1'b0});
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1, 320, 1'b0);
    wait_valid(0, "rs_valid");
    check_head(0, "rs");
    chk("rs_ovr",    32'(u_if0.overrun), 32'd0);
    chk("rs_fe",     32'(fe0 - fe_b), 32'd0);
    chk("rs_vrise1", 32'(vrise0 - vr_b), 32'd1);
    do_ack(0);
    chk("rs_ack_valid", 32'(u_if0.data_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
